// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, iterative 32-step mul/div unit owning HI/LO,
// and the EX/MEM pipeline register. MDStallE holds the front end while a HI/LO op must wait.
module ex_stage #(
    parameter int MD_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] RegD1E,
    input  logic [31:0] RegD2E1,
    input  logic [31:0] SignImmE,
    input  logic [4:0]  ShamtE,
    input  logic [4:0]  RegWriteAddrE1,
    input  logic [4:0]  RegWriteAddrE2,
    input  logic        RegWriteE,
    input  logic        MemtoRegE,
    input  logic        MemWriteE,
    input  logic        ALUSrcAE,
    input  logic        ALUSrcBE,
    input  logic        RegDstE,
    input  logic [4:0]  ALUopE,
    input  logic [1:0]  ForwardAE,
    input  logic [1:0]  ForwardBE,
    input  logic [31:0] ResultW,
    output logic [31:0] ALUOutM,
    output logic [31:0] WriteDataM,
    output logic [4:0]  WriteRegM,
    output logic        RegWriteM,
    output logic        MemtoRegM,
    output logic        MemWriteM,
    output logic        MDStallE
);

    localparam logic [4:0] LAST_STEP = 5'(MD_CYCLES - 1);

    logic [31:0] w_fwd_a, w_fwd_b, w_src_a, w_src_b, w_alu_res;
    logic        w_is_md, w_is_hilo;
    logic [32:0] w_mul_sum, w_div_sh, w_div_diff;
    logic [31:0] w_step_acc, w_step_q, w_fin_hi, w_fin_lo;
    logic [63:0] w_prod;

    logic        r_busy, r_is_div, r_sa, r_sb, r_dz;
    logic [4:0]  r_cnt;
    logic [31:0] r_hi, r_lo, r_acc, r_q, r_opnd_b, r_a_orig;

    function automatic logic [31:0] f_mag(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (32'd0 - v) : v;
    endfunction

    assign w_is_md   = (ALUopE >= 5'd12) && (ALUopE <= 5'd15);
    assign w_is_hilo = (ALUopE >= 5'd12) && (ALUopE <= 5'd19);
    assign MDStallE  = r_busy && w_is_hilo;

    // Operand forwarding and ALU source selection
    always_comb begin
        case (ForwardAE)
            2'b01:   w_fwd_a = ResultW;
            2'b10:   w_fwd_a = ALUOutM;
            default: w_fwd_a = RegD1E;
        endcase
        case (ForwardBE)
            2'b01:   w_fwd_b = ResultW;
            2'b10:   w_fwd_b = ALUOutM;
            default: w_fwd_b = RegD2E1;
        endcase
        if (ALUSrcAE) begin
            w_src_a = {27'd0, ShamtE};
        end else begin
            w_src_a = w_fwd_a;
        end
        if (ALUSrcBE) begin
            w_src_b = SignImmE;
        end else begin
            w_src_b = w_fwd_b;
        end
    end

    // ALU evaluation; HI/LO reads share this result path
    always_comb begin
        w_alu_res = 32'd0;
        case (ALUopE)
            5'd0:    w_alu_res = w_src_a + w_src_b;
            5'd1:    w_alu_res = w_src_a - w_src_b;
            5'd2:    w_alu_res = w_src_a & w_src_b;
            5'd3:    w_alu_res = w_src_a | w_src_b;
            5'd4:    w_alu_res = w_src_a ^ w_src_b;
            5'd5:    w_alu_res = ~(w_src_a | w_src_b);
            5'd6:    w_alu_res = {31'd0, ($signed(w_src_a) < $signed(w_src_b))};
            5'd7:    w_alu_res = {31'd0, (w_src_a < w_src_b)};
            5'd8:    w_alu_res = w_src_b << w_src_a[4:0];
            5'd9:    w_alu_res = w_src_b >> w_src_a[4:0];
            5'd10:   w_alu_res = $signed(w_src_b) >>> w_src_a[4:0];
            5'd11:   w_alu_res = {w_src_b[15:0], 16'd0};
            5'd16:   w_alu_res = r_hi;
            5'd17:   w_alu_res = r_lo;
            default: w_alu_res = 32'd0;
        endcase
    end

    // One engine step: r_acc/r_q hold accumulator+multiplier or remainder+quotient
    always_comb begin
        w_mul_sum  = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_opnd_b} : 33'd0);
        w_div_sh   = {r_acc, r_q[31]};
        w_div_diff = w_div_sh - {1'b0, r_opnd_b};
        if (r_is_div) begin
            if (!w_div_diff[32]) begin
                w_step_acc = w_div_diff[31:0];
                w_step_q   = {r_q[30:0], 1'b1};
            end else begin
                w_step_acc = w_div_sh[31:0];
                w_step_q   = {r_q[30:0], 1'b0};
            end
        end else begin
            w_step_acc = w_mul_sum[32:1];
            w_step_q   = {w_mul_sum[0], r_q[31:1]};
        end
    end

    // Sign fixups and divide-by-zero override applied on the final step
    always_comb begin
        w_prod   = {w_step_acc, w_step_q};
        w_fin_hi = 32'd0;
        w_fin_lo = 32'd0;
        if (r_is_div) begin
            if (r_dz) begin
                w_fin_hi = r_a_orig;
                w_fin_lo = 32'hFFFF_FFFF;
            end else begin
                w_fin_lo = (r_sa ^ r_sb) ? (32'd0 - w_step_q) : w_step_q;
                w_fin_hi = r_sa ? (32'd0 - w_step_acc) : w_step_acc;
            end
        end else begin
            if (r_sa ^ r_sb) begin
                w_prod = 64'd0 - w_prod;
            end else begin
                w_prod = {w_step_acc, w_step_q};
            end
            w_fin_hi = w_prod[63:32];
            w_fin_lo = w_prod[31:0];
        end
    end

    // Mul/div sequencer and HI/LO ownership
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy   <= 1'b0;
            r_cnt    <= 5'd0;
            r_is_div <= 1'b0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_dz     <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_acc    <= 32'd0;
            r_q      <= 32'd0;
            r_opnd_b <= 32'd0;
            r_a_orig <= 32'd0;
        end else if (r_busy) begin
            r_acc <= w_step_acc;
            r_q   <= w_step_q;
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == LAST_STEP) begin
                r_hi   <= w_fin_hi;
                r_lo   <= w_fin_lo;
                r_busy <= 1'b0;
            end
        end else if (w_is_md) begin
            // bit1 selects divide, bit0 selects unsigned
            r_busy   <= 1'b1;
            r_cnt    <= 5'd0;
            r_is_div <= ALUopE[1];
            r_sa     <= !ALUopE[0] && w_src_a[31];
            r_sb     <= !ALUopE[0] && w_src_b[31];
            r_dz     <= (w_src_b == 32'd0);
            r_a_orig <= w_src_a;
            r_acc    <= 32'd0;
            r_q      <= f_mag(w_src_a, !ALUopE[0]);
            r_opnd_b <= f_mag(w_src_b, !ALUopE[0]);
        end else if (ALUopE == 5'd18) begin
            r_hi <= w_fwd_a;
        end else if (ALUopE == 5'd19) begin
            r_lo <= w_fwd_a;
        end
    end

    // EX/MEM register; a stalled cycle loads a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ALUOutM    <= 32'd0;
            WriteDataM <= 32'd0;
            WriteRegM  <= 5'd0;
            RegWriteM  <= 1'b0;
            MemtoRegM  <= 1'b0;
            MemWriteM  <= 1'b0;
        end else if (MDStallE) begin
            ALUOutM    <= 32'd0;
            WriteDataM <= 32'd0;
            WriteRegM  <= 5'd0;
            RegWriteM  <= 1'b0;
            MemtoRegM  <= 1'b0;
            MemWriteM  <= 1'b0;
        end else begin
            ALUOutM    <= w_alu_res;
            WriteDataM <= w_fwd_b;
            WriteRegM  <= RegDstE ? RegWriteAddrE2 : RegWriteAddrE1;
            RegWriteM  <= RegWriteE;
            MemtoRegM  <= MemtoRegE;
            MemWriteM  <= MemWriteE;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU, forwarding, mul/div with stalls, and mid-operation reset.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] RegD1E, RegD2E1, SignImmE, ResultW;
    logic [4:0]  ShamtE, RegWriteAddrE1, RegWriteAddrE2, ALUopE;
    logic        RegWriteE, MemtoRegE, MemWriteE, ALUSrcAE, ALUSrcBE, RegDstE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] ALUOutM, WriteDataM;
    logic [4:0]  WriteRegM;
    logic        RegWriteM, MemtoRegM, MemWriteM, MDStallE;

    int n_cmp = 0;
    int n_err = 0;
    int stalls;

    ex_stage dut (
        .clk(clk), .rst_n(rst_n),
        .RegD1E(RegD1E), .RegD2E1(RegD2E1), .SignImmE(SignImmE), .ShamtE(ShamtE),
        .RegWriteAddrE1(RegWriteAddrE1), .RegWriteAddrE2(RegWriteAddrE2),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
        .ALUSrcAE(ALUSrcAE), .ALUSrcBE(ALUSrcBE), .RegDstE(RegDstE),
        .ALUopE(ALUopE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ResultW(ResultW),
        .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WriteRegM(WriteRegM),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
        .MDStallE(MDStallE)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic rw, input logic [4:0] rd);
        ALUopE = op; RegD1E = a; RegD2E1 = b; RegWriteE = rw;
        RegDstE = 1'b1; RegWriteAddrE2 = rd; RegWriteAddrE1 = 5'd3;
        ForwardAE = 2'b00; ForwardBE = 2'b00; ALUSrcAE = 1'b0; ALUSrcBE = 1'b0;
        MemtoRegE = 1'b0; MemWriteE = 1'b0; ShamtE = 5'd0; SignImmE = 32'd0; ResultW = 32'd0;
        #1;
    endtask

    task automatic wait_stall(output int n);
        n = 0;
        while (MDStallE && n < 64) begin
            tick();
            n++;
        end
        if (n >= 64) chk("stall_timeout", 32'(n), 32'd0);
    endtask

    task automatic md_start(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        drive(op, a, b, 1'b0, 5'd0);
        tick();
    endtask

    task automatic read_hilo(input string tag, input logic [4:0] op, input logic [31:0] exp);
        int n;
        drive(op, 32'd0, 32'd0, 1'b1, 5'd8);
        wait_stall(n);
        tick();
        chk(tag, ALUOutM, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(5'd0, 32'd0, 32'd0, 1'b0, 5'd0);
        #8;
        chk("rst_aluout", ALUOutM, 32'd0);
        chk("rst_wreg", {27'd0, WriteRegM}, 32'd0);
        chk("rst_ctrl", {29'd0, RegWriteM, MemtoRegM, MemWriteM}, 32'd0);
        chk("rst_stall", {31'd0, MDStallE}, 32'd0);
        rst_n = 1'b1;

        drive(5'd0, 32'd7, 32'd5, 1'b1, 5'd9);
        tick();
        chk("add_res", ALUOutM, 32'd12);
        chk("add_wreg", {27'd0, WriteRegM}, 32'd9);
        chk("add_regwr", {31'd0, RegWriteM}, 32'd1);
        chk("add_wdata", WriteDataM, 32'd5);

        drive(5'd0, 32'h10, 32'd0, 1'b1, 5'd9);
        tick();
        drive(5'd1, 32'd100, 32'd100, 1'b1, 5'd9);
        ForwardAE = 2'b10; ForwardBE = 2'b01; ResultW = 32'd3; MemWriteE = 1'b1;
        tick();
        chk("fwd_sub", ALUOutM, 32'hD);
        chk("fwd_wdata", WriteDataM, 32'd3);
        chk("fwd_memwr", {31'd0, MemWriteM}, 32'd1);

        drive(5'd10, 32'd0, 32'hF000_0000, 1'b1, 5'd9);
        ALUSrcAE = 1'b1; ShamtE = 5'd4;
        tick();
        chk("sra", ALUOutM, 32'hFF00_0000);
        drive(5'd9, 32'd4, 32'hF000_0000, 1'b1, 5'd9);
        tick();
        chk("srl", ALUOutM, 32'h0F00_0000);
        drive(5'd6, 32'hFFFF_FFFF, 32'd1, 1'b1, 5'd9);
        tick();
        chk("slt", ALUOutM, 32'd1);
        drive(5'd7, 32'hFFFF_FFFF, 32'd1, 1'b1, 5'd9);
        tick();
        chk("sltu", ALUOutM, 32'd0);
        drive(5'd11, 32'd0, 32'd0, 1'b1, 5'd9);
        ALUSrcBE = 1'b1; SignImmE = 32'h0000_1234;
        tick();
        chk("lui", ALUOutM, 32'h1234_0000);
        drive(5'd5, 32'h0F0F_0000, 32'h0000_00F0, 1'b1, 5'd9);
        tick();
        chk("nor", ALUOutM, 32'hF0F0_FF0F);
        drive(5'd25, 32'd7, 32'd9, 1'b1, 5'd9);
        tick();
        chk("op_unused", ALUOutM, 32'd0);

        md_start(5'd12, 32'hFFFF_FFFD, 32'd7);
        chk("mult_aluout", ALUOutM, 32'd0);
        drive(5'd17, 32'd0, 32'd0, 1'b1, 5'd8);
        chk("mult_stall_on", {31'd0, MDStallE}, 32'd1);
        wait_stall(stalls);
        chk("mult_stall_cnt", 32'(stalls), 32'd32);
        chk("mult_bubble_rw", {31'd0, RegWriteM}, 32'd0);
        chk("mult_bubble_res", ALUOutM, 32'd0);
        tick();
        chk("mult_lo", ALUOutM, 32'hFFFF_FFEB);
        chk("mult_lo_wreg", {27'd0, WriteRegM}, 32'd8);
        read_hilo("mult_hi", 5'd16, 32'hFFFF_FFFF);

        md_start(5'd14, 32'hFFFF_FFF9, 32'd2);
        read_hilo("div_lo", 5'd17, 32'hFFFF_FFFD);
        read_hilo("div_hi", 5'd16, 32'hFFFF_FFFF);

        md_start(5'd15, 32'd7, 32'd0);
        drive(5'd0, 32'd2, 32'd3, 1'b1, 5'd4);
        chk("busy_add_nostall", {31'd0, MDStallE}, 32'd0);
        tick();
        chk("busy_add_res", ALUOutM, 32'd5);
        chk("busy_add_rw", {31'd0, RegWriteM}, 32'd1);
        read_hilo("divu0_hi", 5'd16, 32'd7);
        read_hilo("divu0_lo", 5'd17, 32'hFFFF_FFFF);

        md_start(5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        read_hilo("multu_hi", 5'd16, 32'hFFFF_FFFE);
        read_hilo("multu_lo", 5'd17, 32'h0000_0001);

        md_start(5'd14, 32'h8000_0000, 32'hFFFF_FFFF);
        read_hilo("divovf_lo", 5'd17, 32'h8000_0000);
        read_hilo("divovf_hi", 5'd16, 32'd0);

        drive(5'd18, 32'h0000_ABCD, 32'd0, 1'b0, 5'd0);
        tick();
        read_hilo("mthi", 5'd16, 32'h0000_ABCD);

        md_start(5'd14, 32'd100, 32'd7);
        drive(5'd0, 32'd1, 32'd1, 1'b1, 5'd2);
        for (int i = 0; i < 10; i++) tick();
        chk("pre_rst_add", ALUOutM, 32'd2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_aluout", ALUOutM, 32'd0);
        chk("mid_rst_ctrl", {27'd0, RegWriteM, WriteRegM[3:0]}, 32'd0);
        drive(5'd17, 32'd0, 32'd0, 1'b1, 5'd8);
        chk("mid_rst_nostall", {31'd0, MDStallE}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("mid_rst_lo", ALUOutM, 32'd0);
        chk("mid_rst_lo_rw", {31'd0, RegWriteM}, 32'd1);
        read_hilo("mid_rst_hi", 5'd16, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
